// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache fill / memory arbitration slice.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL_I,
    ST_FILL_D
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam int unsigned BLOCK_WORDS_DEF = 8;
  localparam int unsigned MEM_LATENCY_DEF = 4;

endpackage

// File: rtl/arb_word_counter.sv
// Saturating up-counter with synchronous clear; counts issued and returned fill words.
module arb_word_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined memory between D-cache stores and I/D block fills,
// issuing one word address per cycle and steering returned words to the owning cache.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           d_wr_ack,
  output logic                           i_grant,
  output logic                           d_grant,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_in,
  input  logic [DATA_W-1:0]              mem_data_out,
  input  logic                           mem_data_valid
);

  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS) + 1;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] ALL_WORDS = OFF_W'(BLOCK_WORDS);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

  if ((MEM_LATENCY < 1) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0)) begin : g_param_check
    $error("mem_arbiter: MEM_LATENCY must be >= 1 and BLOCK_WORDS a power of 2");
  end

  arb_state_t           state;
  owner_t               owner;
  owner_t               last_fill;
  owner_t               pick;
  logic [TAG_W-1:0]     tag_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [OFF_W-1:0]     issue_cnt;
  logic [OFF_W-1:0]     ret_cnt;
  logic                 in_fill;
  logic                 issue_active;
  logic                 ret_fire;
  logic                 ret_last;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

  assign in_fill      = (state == ST_FILL_I) || (state == ST_FILL_D);
  assign issue_active = in_fill && (issue_cnt < ALL_WORDS);
  assign ret_fire     = in_fill && mem_data_valid;
  assign ret_last     = ret_fire && (ret_cnt == LAST_WORD);

  arb_word_counter #(
    .W   (OFF_W),
    .MAX (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (in_fill),
    .cnt (issue_cnt)
  );

  arb_word_counter #(
    .W   (OFF_W),
    .MAX (BLOCK_WORDS)
  ) u_ret_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (ret_fire),
    .cnt (ret_cnt)
  );

  // Round robin only matters when both misses are pending; otherwise serve whichever is up.
  always_comb begin
    pick = OWN_NONE;
    if (i_miss && d_miss) begin
      pick = (last_fill == OWN_I) ? OWN_D : OWN_I;
    end else if (d_miss) begin
      pick = OWN_D;
    end else if (i_miss) begin
      pick = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      last_fill <= OWN_I;
      tag_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (d_wr_req) begin
            state     <= ST_WRITE;
            wr_addr_q <= d_wr_addr;
            wr_data_q <= d_wr_data;
          end else if (pick != OWN_NONE) begin
            state <= (pick == OWN_D) ? ST_FILL_D : ST_FILL_I;
            owner <= pick;
            tag_q <= (pick == OWN_D) ? d_miss_addr[ADDR_W-1:OFF_W]
                                     : i_miss_addr[ADDR_W-1:OFF_W];
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        ST_FILL_I, ST_FILL_D: begin
          if (ret_last) begin
            state     <= ST_IDLE;
            last_fill <= owner;
            owner     <= OWN_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Issue side decodes registered state only; return side is qualified by the live valid.
  always_comb begin
    d_wr_ack     = 1'b0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;

    case (state)
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr_q;
        mem_data_in = wr_data_q;
        d_wr_ack    = 1'b1;
      end
      ST_FILL_I: i_grant = 1'b1;
      ST_FILL_D: d_grant = 1'b1;
      default: ;
    endcase

    if (issue_active) begin
      mem_enable = 1'b1;
      mem_addr   = {tag_q, issue_cnt[OFF_W-2:0], 1'b0};
    end

    if (ret_fire) begin
      fill_data    = mem_data_out;
      fill_word    = ret_cnt[OFF_W-2:0];
      i_fill_valid = (owner == OWN_I);
      d_fill_valid = (owner == OWN_D);
      i_fill_done  = ret_last && (owner == OWN_I);
      d_fill_done  = ret_last && (owner == OWN_D);
    end
  end

endmodule
